// File: rtl/fp_add_pkg.sv
// Shared encodings and constants for the FP adder controller and datapath.
package fp_add_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_HOLD
  } state_t;

  localparam int         NORM_MAX_DEF = 24;
  localparam logic [7:0] EXP_MAX      = 8'hFF;

endpackage

// File: rtl/fp_add_seq_ctrl_if.sv
// Operand-in / result-out valid-ready handshake of the FP add controller.
interface fp_add_seq_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

endinterface

// File: rtl/fp_add_seq_ctrl.sv
// Sequencing FSM and normalisation counter for the external FP add datapath.
module fp_add_seq_ctrl
  import fp_add_pkg::*;
#(
  parameter int NORM_MAX = NORM_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  fp_add_seq_ctrl_if.slave hs,
  input  logic msb_set,
  input  logic mant_zero,
  input  logic round_carry,
  input  logic exp_ovf,
  output logic ld_op,
  output logic en_align,
  output logic en_add,
  output logic en_shift,
  output logic en_round,
  output logic en_pack,
  output logic overflow,
  output logic zero_res
);

  localparam int CW = $clog2(NORM_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(NORM_MAX);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          renorm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      renorm       <= 1'b0;
      overflow     <= 1'b0;
      zero_res     <= 1'b0;
      ld_op        <= 1'b0;
      en_align     <= 1'b0;
      en_add       <= 1'b0;
      en_shift     <= 1'b0;
      en_round     <= 1'b0;
      en_pack      <= 1'b0;
      hs.out_valid <= 1'b0;
      hs.in_ready  <= 1'b1;
    end else begin
      ld_op    <= 1'b0;
      en_align <= 1'b0;
      en_add   <= 1'b0;
      en_shift <= 1'b0;
      en_round <= 1'b0;
      en_pack  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hs.in_valid) begin
            state       <= S_LOAD;
            hs.in_ready <= 1'b0;
            ld_op       <= 1'b1;
            cnt         <= '0;
            renorm      <= 1'b0;
            overflow    <= 1'b0;
            zero_res    <= 1'b0;
          end
        end
        S_LOAD: begin
          state    <= S_ALIGN;
          en_align <= 1'b1;
        end
        S_ALIGN: begin
          state  <= S_ADD;
          en_add <= 1'b1;
        end
        S_ADD: begin
          state <= S_NORM;
        end
        // Status priority: zero, overflow, normalised, shift budget spent.
        S_NORM: begin
          if (mant_zero) begin
            zero_res <= 1'b1;
            state    <= S_PACK;
            en_pack  <= 1'b1;
          end else if (exp_ovf) begin
            overflow <= 1'b1;
            state    <= S_PACK;
            en_pack  <= 1'b1;
          end else if (msb_set) begin
            state    <= S_ROUND;
            en_round <= 1'b1;
          end else if (cnt == CMAX) begin
            zero_res <= 1'b1;
            state    <= S_PACK;
            en_pack  <= 1'b1;
          end else begin
            en_shift <= 1'b1;
            cnt      <= cnt + CW'(1);
          end
        end
        // Only one renormalisation pass is allowed per operation.
        S_ROUND: begin
          if (exp_ovf) begin
            overflow <= 1'b1;
            state    <= S_PACK;
            en_pack  <= 1'b1;
          end else if (round_carry && !renorm) begin
            renorm <= 1'b1;
            state  <= S_NORM;
          end else begin
            state   <= S_PACK;
            en_pack <= 1'b1;
          end
        end
        S_PACK: begin
          state        <= S_HOLD;
          hs.out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (hs.out_ready) begin
            state        <= S_IDLE;
            hs.out_valid <= 1'b0;
            hs.in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Randomised scoreboard bench for the FP add sequencing controller.
module tb_fp_add_seq_ctrl;

  localparam int NMAX = 24;

  typedef struct {
    int lat;
    int ns;
    int nr;
    bit ovf;
    bit zr;
    int hold;
  } exp_t;

  typedef struct {
    int s0; int k0; bit rc0; bit ro0;
    int s1; int k1; bit rc1; bit ro1;
    int hold;
  } plan_t;

  logic clk = 1'b0;
  logic rst;
  logic msb_set, mant_zero, round_carry, exp_ovf;
  logic ld_op, en_align, en_add, en_shift, en_round, en_pack;
  logic overflow, zero_res;

  fp_add_seq_ctrl_if hs ();

  fp_add_seq_ctrl #(.NORM_MAX(NMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .msb_set     (msb_set),
    .mant_zero   (mant_zero),
    .round_carry (round_carry),
    .exp_ovf     (exp_ovf),
    .ld_op       (ld_op),
    .en_align    (en_align),
    .en_add      (en_add),
    .en_shift    (en_shift),
    .en_round    (en_round),
    .en_pack     (en_pack),
    .overflow    (overflow),
    .zero_res    (zero_res)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  exp_t       sb[$];
  logic [3:0] stim_q[$];

  function automatic void chk(input bit ok, input string nm,
                              input int act, input int exv);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exv);
    end
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic plan_t mk(input int s0, k0, input bit rc0, ro0,
                               input int s1, k1, input bit rc1, ro1,
                               input int hold);
    plan_t p;
    p.s0 = s0; p.k0 = k0; p.rc0 = rc0; p.ro0 = ro0;
    p.s1 = s1; p.k1 = k1; p.rc1 = rc1; p.ro1 = ro1;
    p.hold = hold;
    return p;
  endfunction

  // Reference: walk the operation phase by phase, producing per-cycle
  // status stimulus {ovf,carry,zero,msb} and the expected outcome.
  // Plan kind k: 0 = leading one found, 1 = zero sum, 2 = exponent overflow.
  task automatic build(input plan_t p, output exp_t e);
    int  cnt, v, j, s, k;
    bit  renorm, done, ended, to_round, rc, ro;
    stim_q.delete();
    e.lat = 0; e.ns = 0; e.nr = 0;
    e.ovf = 0; e.zr = 0; e.hold = p.hold + 1;
    repeat (3) stim_q.push_back(4'($urandom_range(0, 15)));
    cnt = 0; v = 0; renorm = 0; done = 0;
    while (!done) begin
      s = v ? p.s1 : p.s0;
      k = v ? p.k1 : p.k0;
      j = 0; ended = 0; to_round = 0;
      while (!ended) begin
        if (j < s) begin
          stim_q.push_back({1'b0, rb(), 1'b0, 1'b0});
          if (cnt == NMAX) begin
            e.zr = 1; ended = 1;
          end else begin
            cnt++; e.ns++;
          end
          j++;
        end else begin
          case (k)
            1: begin stim_q.push_back({rb(), rb(), 1'b1, rb()}); e.zr = 1; end
            2: begin stim_q.push_back({1'b1, rb(), 1'b0, rb()}); e.ovf = 1; end
            default: begin stim_q.push_back({1'b0, rb(), 1'b0, 1'b1}); to_round = 1; end
          endcase
          ended = 1;
        end
      end
      done = 1;
      if (to_round) begin
        rc = v ? p.rc1 : p.rc0;
        ro = v ? p.ro1 : p.ro0;
        e.nr++;
        stim_q.push_back({ro, rc, rb(), rb()});
        if (ro) e.ovf = 1;
        else if (rc && !renorm) begin
          renorm = 1; v = 1; done = 0;
        end
      end
    end
    stim_q.push_back(4'($urandom_range(0, 15)));
    e.lat = stim_q.size() + 1;
  endtask

  task automatic drive_status(input logic [3:0] st);
    {exp_ovf, round_carry, mant_zero, msb_set} = st;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!hs.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = hs.in_ready;
    if (!ok) chk(0, "in_ready_timeout", 0, 1);
  endtask

  task automatic run_op(input plan_t p);
    exp_t       e;
    bit         ok;
    logic [3:0] st;
    build(p, e);
    wait_idle(ok);
    if (!ok) return;
    sb.push_back(e);
    hs.in_valid = 1'b1;
    foreach (stim_q[i]) begin
      @(negedge clk);
      st = stim_q[i];
      drive_status(st);
      hs.in_valid  = rb();
      hs.out_ready = rb();
    end
    for (int h = 0; h <= p.hold; h++) begin
      @(negedge clk);
      drive_status(4'($urandom_range(0, 15)));
      hs.in_valid  = rb();
      hs.out_ready = (h == p.hold);
    end
    @(negedge clk);
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    drive_status(4'b0);
  endtask

  // Monitor: tracks strobes from ld_op onward and scores each result.
  int   cyc, ns, nr, np, pc, ac, dc, hn;
  bit   active, in_hold;
  exp_t cur;

  initial begin
    active = 0; in_hold = 0;
    cyc = 0; ns = 0; nr = 0; np = 0; pc = 0; ac = 0; dc = 0; hn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; in_hold = 0;
      end else begin
        chk($countones({ld_op, en_align, en_add, en_shift, en_round, en_pack}) <= 1,
            "strobe_onehot",
            int'($countones({ld_op, en_align, en_add, en_shift, en_round, en_pack})), 1);
        if (ld_op) begin
          active = 1; cyc = 1;
          ns = 0; nr = 0; np = 0; pc = 0; ac = 0; dc = 0;
        end else if (active) cyc++;
        if (active) begin
          chk(hs.in_ready == 1'b0, "in_ready_busy", int'(hs.in_ready), 0);
          if (en_shift) ns++;
          if (en_round) nr++;
          if (en_align) ac = cyc;
          if (en_add) dc = cyc;
          if (en_pack) begin np++; pc = cyc; end
        end
        if (hs.out_valid && !in_hold) begin
          in_hold = 1; hn = 0;
          if (sb.size() == 0) chk(0, "unexpected_out_valid", 1, 0);
          else begin
            cur = sb.pop_front();
            chk(active && cyc == cur.lat, "latency", cyc, cur.lat);
            chk(ns == cur.ns, "shift_count", ns, cur.ns);
            chk(nr == cur.nr, "round_count", nr, cur.nr);
            chk(np == 1 && pc == cur.lat - 1, "pack_cycle", pc, cur.lat - 1);
            chk(ac == 2 && dc == 3, "align_add_cycles", ac * 10 + dc, 23);
          end
          active = 0;
        end
        if (hs.out_valid) begin
          hn++;
          chk(overflow == cur.ovf, "overflow", int'(overflow), int'(cur.ovf));
          chk(zero_res == cur.zr, "zero_res", int'(zero_res), int'(cur.zr));
        end else if (in_hold) begin
          in_hold = 0;
          chk(hn == cur.hold, "hold_length", hn, cur.hold);
          chk(hs.in_ready == 1'b1, "in_ready_idle", int'(hs.in_ready), 1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk(hs.in_ready == 1'b1, {nm, "_in_ready"}, int'(hs.in_ready), 1);
    chk(hs.out_valid == 1'b0, {nm, "_out_valid"}, int'(hs.out_valid), 0);
    chk({ld_op, en_align, en_add, en_shift, en_round, en_pack} == 6'b0,
        {nm, "_strobes"},
        int'({ld_op, en_align, en_add, en_shift, en_round, en_pack}), 0);
    chk({overflow, zero_res} == 2'b0, {nm, "_flags"},
        int'({overflow, zero_res}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ok;
    plan_t p;
    rst = 1'b1;
    hs.in_valid = 1'b0;
    hs.out_ready = 1'b0;
    drive_status(4'b0);
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_op(mk(3, 0, 0, 0, 0, 0, 0, 0, 0));
    run_op(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
    run_op(mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
    run_op(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    run_op(mk(30, 0, 0, 0, 0, 0, 0, 0, 2));
    run_op(mk(2, 2, 0, 0, 0, 0, 0, 0, 5));
    run_op(mk(1, 1, 0, 0, 0, 0, 0, 0, 5));
    run_op(mk(20, 0, 1, 0, 10, 0, 0, 0, 0));

    // Asynchronous reset while the FSM is shifting in NORM.
    wait_idle(ok);
    if (ok) begin
      hs.in_valid = 1'b1;
      @(negedge clk);
      hs.in_valid = 1'b0;
      drive_status(4'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midop_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end

    for (int n = 0; n < 40; n++) begin
      p.s0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 30))
                                         : int'($urandom_range(0, 5));
      p.s1 = int'($urandom_range(0, 6));
      p.k0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      p.k1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      p.rc0 = rb();
      p.rc1 = rb();
      p.ro0 = ($urandom_range(0, 3) == 0);
      p.ro1 = ($urandom_range(0, 3) == 0);
      p.hold = int'($urandom_range(0, 4));
      run_op(p);
    end

    repeat (3) @(negedge clk);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
